// File: rtl/otp_pkg.sv
// Shared OTP definitions: FSM encoding, response status codes and fuse map.
// Imported by the programming controller and the boot-time OTP agent.
package otp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_PGM,
        ST_VRD,
        ST_VCAP,
        ST_RESP
    } otp_state_t;

    typedef enum logic [1:0] {
        OTP_ST_OK          = 2'b00,
        OTP_ST_ALREADY     = 2'b01,
        OTP_ST_VERIFY_FAIL = 2'b10,
        OTP_ST_LOCKED      = 2'b11
    } otp_status_t;

    // Secure-debug-disable fuse location, sampled by the boot agent.
    localparam logic [31:0] OTP_SDD_ADDR = 32'h0000_0010;
    localparam int unsigned OTP_SDD_BIT  = 0;

endpackage

// File: rtl/otp_pulse_timer.sv
// Loadable down-counter timing the dwell of one OTP program pulse.
// done_o marks the last cycle of the pulse.
module otp_pulse_timer #(
    parameter int unsigned CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);

    localparam int unsigned W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= W'(CYCLES);
        end else if (en_i && cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/otp_prog_ctrl.sv
// OTP fuse programming controller: read-check-program-verify of one word
// per request, with bounded re-pulsing on verify failure.
module otp_prog_ctrl
    import otp_pkg::*;
#(
    parameter int unsigned BUS_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned PULSE_CYCLES = 16,
    parameter int unsigned MAX_RETRY    = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    prog_lock,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [BUS_WIDTH-1:0]    req_addr,
    input  logic [DATA_WIDTH-1:0]   req_mask,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [1:0]              rsp_status,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [BUS_WIDTH-1:0]    s_ram_raddr,
    output logic                    s_ram_ren,
    input  logic [DATA_WIDTH-1:0]   s_ram_rdata,
    output logic [BUS_WIDTH-1:0]    s_ram_waddr,
    output logic [DATA_WIDTH-1:0]   s_ram_wdata,
    output logic [DATA_WIDTH/8-1:0] s_ram_wen
);

    localparam int unsigned NB = DATA_WIDTH / 8;

    otp_state_t            state_q;
    logic [BUS_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0] mask_q;
    logic [2:0]            retry_q;

    logic [DATA_WIDTH-1:0] burn_c;
    logic [NB-1:0]         wen_c;
    logic                  mask_ok_c;
    logic                  pulse_done;

    // Only bits still reading 0 are ever driven, so burned fuses are untouched.
    always_comb begin
        burn_c    = mask_q & ~s_ram_rdata;
        mask_ok_c = ((s_ram_rdata & mask_q) == mask_q);
        wen_c     = '0;
        for (int i = 0; i < NB; i++) begin
            wen_c[i] = |burn_c[8*i +: 8];
        end
    end

    otp_pulse_timer #(
        .CYCLES (PULSE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (resetn),
        .load_i (state_q != ST_PGM),
        .en_i   (state_q == ST_PGM),
        .done_o (pulse_done)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            mask_q      <= '0;
            retry_q     <= '0;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_status  <= OTP_ST_OK;
            rsp_rdata   <= '0;
            s_ram_raddr <= '0;
            s_ram_ren   <= 1'b0;
            s_ram_waddr <= '0;
            s_ram_wdata <= '0;
            s_ram_wen   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        addr_q    <= req_addr;
                        mask_q    <= req_mask;
                        retry_q   <= '0;
                        if (prog_lock) begin
                            rsp_status <= OTP_ST_LOCKED;
                            rsp_rdata  <= '0;
                            state_q    <= ST_RESP;
                        end else begin
                            s_ram_raddr <= req_addr;
                            s_ram_ren   <= 1'b1;
                            state_q     <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    s_ram_ren <= 1'b0;
                    state_q   <= ST_CAP;
                end
                ST_CAP: begin
                    if (burn_c == '0) begin
                        rsp_valid  <= 1'b1;
                        rsp_status <= OTP_ST_ALREADY;
                        rsp_rdata  <= s_ram_rdata;
                        state_q    <= ST_RESP;
                    end else begin
                        s_ram_waddr <= addr_q;
                        s_ram_wdata <= burn_c;
                        s_ram_wen   <= wen_c;
                        state_q     <= ST_PGM;
                    end
                end
                ST_PGM: begin
                    if (pulse_done) begin
                        s_ram_wen   <= '0;
                        s_ram_wdata <= '0;
                        s_ram_raddr <= addr_q;
                        s_ram_ren   <= 1'b1;
                        state_q     <= ST_VRD;
                    end
                end
                ST_VRD: begin
                    s_ram_ren <= 1'b0;
                    state_q   <= ST_VCAP;
                end
                ST_VCAP: begin
                    if (mask_ok_c) begin
                        rsp_valid  <= 1'b1;
                        rsp_status <= OTP_ST_OK;
                        rsp_rdata  <= s_ram_rdata;
                        state_q    <= ST_RESP;
                    end else if (retry_q < 3'(MAX_RETRY)) begin
                        retry_q     <= retry_q + 3'd1;
                        s_ram_wdata <= burn_c;
                        s_ram_wen   <= wen_c;
                        state_q     <= ST_PGM;
                    end else begin
                        rsp_valid  <= 1'b1;
                        rsp_status <= OTP_ST_VERIFY_FAIL;
                        rsp_rdata  <= s_ram_rdata;
                        state_q    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // Locked requests arrive here with rsp_valid still low.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
